// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry PC+instruction buffer that parks a response while decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic                clear,
  input  logic                drain,
  input  logic [WordSize-1:0] in_pc,
  input  logic [WordSize-1:0] in_instr,
  output logic                full,
  output logic [WordSize-1:0] out_pc,
  output logic [WordSize-1:0] out_instr
);

  logic                full_q, full_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [WordSize-1:0] instr_q, instr_d;

  // clear wins over load, load wins over drain
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= WordSize'(NOP_INSTR);
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full      = full_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC register, one-outstanding imem fetch FSM, redirect squash
// and the decode-facing output register with a single skid entry.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          WordSize    = 32,
  parameter logic [WordSize-1:0]  ResetVector = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] branch_addr,
  input  logic                stall,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                if_valid,
  output logic [WordSize-1:0] if_pc,
  output logic [WordSize-1:0] if_instr
);

  fetch_state_t        state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [WordSize-1:0] pend_pc_q, pend_pc_d;
  logic                squash_q, squash_d;
  logic                imem_req_q, imem_req_d;
  logic                if_valid_q, if_valid_d;
  logic [WordSize-1:0] if_pc_q, if_pc_d;
  logic [WordSize-1:0] if_instr_q, if_instr_d;

  logic                skid_load, skid_clear, skid_drain, skid_full;
  logic [WordSize-1:0] skid_pc, skid_instr;
  logic                fire;
  logic [WordSize-1:0] redirect_pc;

  // imem_req_q mirrors "state is FETCH" but stays low while in reset
  assign fire        = imem_req_q && imem_gnt;
  assign redirect_pc = {branch_addr[WordSize-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    squash_d   = squash_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_drain = 1'b0;

    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        if (fire) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + WordSize'(INSTR_BYTES);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else if (!if_valid_q || !stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = pend_pc_q;
            if_instr_d = imem_rdata;
            state_d    = FETCH;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if (skid_full) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc;
            if_instr_d = skid_instr;
            skid_drain = 1'b1;
          end
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A redirect overrides everything; a request already in flight must be squashed
    if (branch_taken) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b1;
      if ((state_q == WAIT && !imem_rvalid) || fire) begin
        squash_d = 1'b1;
        state_d  = WAIT;
      end else begin
        squash_d = 1'b0;
        state_d  = FETCH;
      end
    end

    imem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= FETCH;
      pc_q       <= ResetVector;
      pend_pc_q  <= '0;
      squash_q   <= 1'b0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= WordSize'(NOP_INSTR);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      squash_q   <= squash_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  fetch_skid_buf #(
    .WordSize (WordSize)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .load      (skid_load),
    .clear     (skid_clear),
    .drain     (skid_drain),
    .in_pc     (pend_pc_q),
    .in_instr  (imem_rdata),
    .full      (skid_full),
    .out_pc    (skid_pc),
    .out_instr (skid_instr)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a
// program-order model (expected fetch/deliver PCs, memory contents derived from address).
module tb_pc_fetch_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         branch_taken;
  logic [W-1:0] branch_addr;
  logic         stall;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  logic         imem_req,  if_valid;
  logic [W-1:0] imem_addr, if_pc, if_instr;
  logic         imem_req2, if_valid2;
  logic [W-1:0] imem_addr2, if_pc2, if_instr2;

  always #5 clk = ~clk;

  pc_fetch_unit #(.WordSize(W), .ResetVector(32'h0)) dut (
    .clk(clk), .rstn(rstn), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  // Second instance only exercises the wrapping reset vector
  pc_fetch_unit #(.WordSize(W), .ResetVector(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rstn(rstn), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .stall(stall), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid2),
    .if_pc(if_pc2), .if_instr(if_instr2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // memory model
  logic         mem_pend;
  logic [W-1:0] mem_addr;
  int           mem_wait;
  // program-order model
  logic [W-1:0] exp_fetch, exp_deliver;
  logic         prev_branch, prev_hold;
  logic [W-1:0] prev_pc, prev_instr;
  int           since;
  logic [W-1:0] req_q[$];
  logic [W-1:0] deliv_q[$];
  logic [W-1:0] req2_q[$];
  // stimulus control
  logic         rand_mode;
  logic         force_stall;
  int           lat_fixed;
  int           branch_mode;
  logic [W-1:0] force_target;
  logic         br_fired;
  int           br_req_idx, br_del_idx;
  int           n_deliv;

  task automatic init_model();
    mem_pend    = 1'b0;
    mem_addr    = '0;
    mem_wait    = 0;
    exp_fetch   = 32'h0;
    exp_deliver = 32'h0;
    prev_branch = 1'b0;
    prev_hold   = 1'b0;
    prev_pc     = '0;
    prev_instr  = '0;
    since       = 0;
    req_q.delete();
    deliv_q.delete();
  endtask

  // One clock: sample/check at negedge, drive inputs, advance the model for the coming edge
  task automatic cycle();
    logic fire;
    @(negedge clk);
    if (prev_branch) begin
      check_eq("redirect_clears_valid", if_valid, 0);
    end else if (prev_hold) begin
      check_eq("stall_holds_valid", if_valid, 1);
      check_eq("stall_holds_pc", if_pc, prev_pc);
      check_eq("stall_holds_instr", if_instr, prev_instr);
    end
    if (if_valid) check_eq("instr_matches_pc", if_instr, mem_word(if_pc));
    if (imem_req) begin
      check_eq("one_outstanding", mem_pend, 0);
      check_eq("addr_aligned", imem_addr[1:0], 0);
    end

    if (mem_pend && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    fire = 1'b0;
    if (rand_mode) begin
      imem_gnt     = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr  = $urandom;
    end else begin
      imem_gnt = 1'b1;
      stall    = force_stall;
      case (branch_mode)
        1:       fire = imem_req;
        2:       fire = !imem_req && mem_pend && !imem_rvalid;
        default: fire = 1'b0;
      endcase
      branch_taken = fire;
      branch_addr  = force_target;
      if (fire) branch_mode = 0;
    end

    if (imem_req2 && imem_gnt && req2_q.size() < 2) req2_q.push_back(imem_addr2);

    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_wait--;
    if (imem_req && imem_gnt) begin
      check_eq("fetch_addr", imem_addr, exp_fetch);
      req_q.push_back(imem_addr);
      exp_fetch = exp_fetch + 32'd4;
      mem_pend  = 1'b1;
      mem_addr  = imem_addr;
      mem_wait  = rand_mode ? int'($urandom_range(0, 2)) : lat_fixed;
    end
    if (branch_taken) begin
      exp_fetch   = {branch_addr[W-1:2], 2'b00};
      exp_deliver = {branch_addr[W-1:2], 2'b00};
    end else if (if_valid && !stall) begin
      check_eq("deliver_pc", if_pc, exp_deliver);
      deliv_q.push_back(if_pc);
      exp_deliver = exp_deliver + 32'd4;
      since = 0;
      n_deliv++;
    end else begin
      since++;
      if (since > 60) begin
        check_eq("progress_cycles", since, 60);
        since = 0;
      end
    end
    prev_branch = branch_taken;
    prev_hold   = if_valid && stall && !branch_taken;
    prev_pc     = if_pc;
    prev_instr  = if_instr;
    if (fire) begin
      br_fired   = 1'b1;
      br_req_idx = req_q.size();
      br_del_idx = deliv_q.size();
    end
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    stall        = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_if_instr", if_instr, 32'h0000_0013);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    check_eq("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    rstn = 1'b1;
    init_model();
    req2_q.delete();
    @(negedge clk);
    check_eq("req_after_release", imem_req, 1);
  endtask

  task automatic check_branch_result(input string tag, input logic [W-1:0] tgt);
    if (br_fired && req_q.size() > br_req_idx) check_eq({tag, "_fetch"}, req_q[br_req_idx], tgt);
    else check_eq({tag, "_fetch_seen"}, 0, 1);
    if (br_fired && deliv_q.size() > br_del_idx) check_eq({tag, "_deliver"}, deliv_q[br_del_idx], tgt);
    else check_eq({tag, "_deliver_seen"}, 0, 1);
  endtask

  initial begin
    logic found;
    rand_mode   = 1'b0;
    force_stall = 1'b0;
    lat_fixed   = 0;
    branch_mode = 0;
    force_target = '0;
    br_fired    = 1'b0;
    br_req_idx  = 0;
    br_del_idx  = 0;
    n_deliv     = 0;

    // zero-wait memory, no stall: fetches 0,4,8 delivered in order
    do_reset();
    repeat (8) cycle();
    if (req_q.size() >= 3) begin
      check_eq("seq_fetch0", req_q[0], 32'h0);
      check_eq("seq_fetch1", req_q[1], 32'h4);
      check_eq("seq_fetch2", req_q[2], 32'h8);
    end else check_eq("seq_fetch_count", req_q.size(), 3);
    if (deliv_q.size() >= 3) begin
      check_eq("seq_deliver0", deliv_q[0], 32'h0);
      check_eq("seq_deliver1", deliv_q[1], 32'h4);
      check_eq("seq_deliver2", deliv_q[2], 32'h8);
    end else check_eq("seq_deliver_count", deliv_q.size(), 3);
    if (req2_q.size() == 2) begin
      check_eq("wrap_fetch0", req2_q[0], 32'hFFFF_FFFC);
      check_eq("wrap_fetch1", req2_q[1], 32'h0000_0000);
    end else check_eq("wrap_fetch_count", req2_q.size(), 2);

    // long stall: response parks, no request while parked
    force_stall = 1'b1;
    repeat (5) cycle();
    check_eq("hold_no_req", imem_req, 0);
    check_eq("hold_valid", if_valid, 1);
    force_stall = 1'b0;
    repeat (6) cycle();

    // redirect coincident with a grant, unaligned target
    br_fired = 1'b0; force_target = 32'h83; branch_mode = 1;
    repeat (10) cycle();
    check_branch_result("redir_on_grant", 32'h80);

    // redirect while waiting on a slower response
    lat_fixed = 1;
    br_fired = 1'b0; force_target = 32'h40; branch_mode = 2;
    repeat (12) cycle();
    check_branch_result("redir_in_wait", 32'h40);
    lat_fixed = 0;

    // randomized traffic
    rand_mode = 1'b1;
    n_deliv   = 0;
    repeat (3000) cycle();
    check_eq("random_progress", (n_deliv > 100), 1);
    rand_mode    = 1'b0;
    branch_taken = 1'b0;

    // asynchronous reset while waiting with valid output
    do_reset();
    force_stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (!imem_req && if_valid) found = 1'b1;
    end
    check_eq("found_wait_with_valid", found, 1);
    rstn = 1'b0;
    #1;
    check_eq("midrst_if_valid", if_valid, 0);
    check_eq("midrst_if_instr", if_instr, 32'h0000_0013);
    check_eq("midrst_imem_req", imem_req, 0);
    check_eq("midrst_imem_addr", imem_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
